execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : execute_muldiv
//  Brief    : RV execute stage: single-cycle ALU/branch unit plus a
//             multi-cycle M-extension unit (fixed-latency multiply, restoring
//             divide) feeding the EX/MEM pipeline register.
//  Revision : 1.0
// ============================================================================
module execute_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc4,
    input  logic [XLEN-1:0] i_r1,
    input  logic [XLEN-1:0] i_r2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_wb_fw_data,
    input  logic [XLEN-1:0] i_mem_fw_data,
    input  logic            i_r1_sel,
    input  logic            i_r2_sel,
    input  logic [1:0]      i_r1_fw_sel,
    input  logic [1:0]      i_r2_fw_sel,
    input  logic [2:0]      i_func3,
    input  logic            i_instr30,
    input  logic [1:0]      i_alu_op,
    input  logic [1:0]      i_branch_op,
    input  logic            i_is_muldiv,
    input  logic            i_mem_w_en,
    input  logic            i_wb_en,
    input  logic [4:0]      i_w_idx,
    input  logic [1:0]      i_wb_sel,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_alu_res,
    output logic [XLEN-1:0] o_rs2,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_mem_w_en,
    output logic            o_wb_en,
    output logic [2:0]      o_func3,
    output logic [4:0]      o_w_idx,
    output logic [1:0]      o_wb_sel,
    output logic [XLEN-1:0] o_alu_res_wire,
    output logic            o_do_branch
);

    localparam int                 c_SHAMT_W  = $clog2(XLEN);
    localparam int                 c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(XLEN - 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XLEN-1:0]      w_r1, w_r2, w_op1, w_op2, w_alu, w_sra;
    logic [c_SHAMT_W-1:0] w_shamt;
    logic                 w_cond, w_taken, w_start, w_stall;

    // ---------------- operand forwarding ----------------
    always_comb begin
        case (i_r1_fw_sel)
            2'd1:    w_r1 = i_mem_fw_data;
            2'd2:    w_r1 = i_wb_fw_data;
            default: w_r1 = i_r1;
        endcase
        case (i_r2_fw_sel)
            2'd1:    w_r2 = i_mem_fw_data;
            2'd2:    w_r2 = i_wb_fw_data;
            default: w_r2 = i_r2;
        endcase
    end

    assign w_op1   = i_r1_sel ? i_pc  : w_r1;
    assign w_op2   = i_r2_sel ? i_imm : w_r2;
    assign w_shamt = w_op2[c_SHAMT_W-1:0];
    assign w_sra   = $signed(w_op1) >>> w_shamt;

    // alu_op: 00 add (address/auipc), 01 pass op2 (lui), 10 R-type, 11 I-type
    always_comb begin
        w_alu = '0;
        if (i_alu_op == 2'b00) begin
            w_alu = w_op1 + w_op2;
        end else if (i_alu_op == 2'b01) begin
            w_alu = w_op2;
        end else begin
            case (i_func3)
                3'b000: begin
                    if (i_alu_op == 2'b10 && i_instr30) w_alu = w_op1 - w_op2;
                    else                                w_alu = w_op1 + w_op2;
                end
                3'b001: w_alu = w_op1 << w_shamt;
                3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
                3'b011: w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
                3'b100: w_alu = w_op1 ^ w_op2;
                3'b101: begin
                    if (i_instr30) w_alu = w_sra;
                    else           w_alu = w_op1 >> w_shamt;
                end
                3'b110: w_alu = w_op1 | w_op2;
                default: w_alu = w_op1 & w_op2;
            endcase
        end
    end

    assign o_alu_res_wire = w_alu;

    // branch_op: 00 none, 01 conditional on func3, 1x unconditional jump
    always_comb begin
        w_cond = 1'b0;
        case (i_func3)
            3'b000:  w_cond = (w_r1 == w_r2);
            3'b001:  w_cond = (w_r1 != w_r2);
            3'b100:  w_cond = ($signed(w_r1) <  $signed(w_r2));
            3'b101:  w_cond = ($signed(w_r1) >= $signed(w_r2));
            3'b110:  w_cond = (w_r1 <  w_r2);
            3'b111:  w_cond = (w_r1 >= w_r2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken     = i_branch_op[1] | ((i_branch_op == 2'b01) & w_cond);
    assign o_do_branch = i_valid & ~i_flush & ~i_is_muldiv & w_taken;

    // ---------------- muldiv control ----------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_a, r_b, r_rem, r_quo;
    logic [2:0]         r_f3;
    logic [2*XLEN-1:0]  r_prod;

    assign w_start = (r_state == S_IDLE) & i_valid & i_is_muldiv & ~i_flush;
    assign w_stall = ~rst & ~i_flush & (w_start | (r_state == S_BUSY));
    assign o_stall = w_stall;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
                S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- multiply datapath ----------------
    logic              w_a_sgn_mul, w_b_sgn_mul;
    logic [2*XLEN-1:0] w_ea, w_eb, w_prod;

    assign w_a_sgn_mul = (r_f3[1:0] == 2'b01) | (r_f3[1:0] == 2'b10);
    assign w_b_sgn_mul = (r_f3[1:0] == 2'b01);
    assign w_ea   = {{XLEN{w_a_sgn_mul & r_a[XLEN-1]}}, r_a};
    assign w_eb   = {{XLEN{w_b_sgn_mul & r_b[XLEN-1]}}, r_b};
    // Low 2*XLEN bits of the extended product are exact for every sign mix
    assign w_prod = w_ea * w_eb;

    // ---------------- divide datapath ----------------
    logic            w_in_neg, w_a_neg, w_b_neg, w_ge, w_div_zero;
    logic [XLEN-1:0] w_abs_in, w_dvs, w_rem_sub, w_quo_fix, w_rem_fix, w_md_res;
    logic [XLEN:0]   w_rem_sh;

    assign w_in_neg   = i_func3[2] & ~i_func3[0] & w_r1[XLEN-1];
    assign w_abs_in   = w_in_neg ? -w_r1 : w_r1;
    assign w_a_neg    = ~r_f3[0] & r_a[XLEN-1];
    assign w_b_neg    = ~r_f3[0] & r_b[XLEN-1];
    assign w_dvs      = w_b_neg ? -r_b : r_b;
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, w_dvs});
    assign w_rem_sub  = w_rem_sh[XLEN-1:0] - w_dvs;
    assign w_div_zero = (r_b == '0);

    always_comb begin
        w_quo_fix = r_quo;
        w_rem_fix = r_rem;
        if (w_div_zero) begin
            w_quo_fix = '1;
            w_rem_fix = r_a;
        end else begin
            if (w_a_neg ^ w_b_neg) w_quo_fix = -r_quo;
            if (w_a_neg)           w_rem_fix = -r_rem;
        end
    end

    always_comb begin
        case (r_f3)
            3'b000:          w_md_res = r_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          w_md_res = r_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  w_md_res = w_quo_fix;
            default:         w_md_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_f3   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_prod <= '0;
        end else if (w_start) begin
            r_a   <= w_r1;
            r_b   <= w_r2;
            r_f3  <= i_func3;
            r_cnt <= i_func3[2] ? c_DIV_LOAD : c_MUL_LOAD;
            r_quo <= w_abs_in;
            r_rem <= '0;
        end else if (r_state == S_BUSY && !i_flush) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            r_prod <= w_prod;
            if (r_f3[2]) begin
                r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], w_ge};
            end
        end
    end

    // ---------------- EX/MEM register ----------------
    logic            r_valid, r_mem_w_en, r_wb_en;
    logic [XLEN-1:0] r_alu_res, r_rs2, r_pc4;
    logic [2:0]      r_func3;
    logic [4:0]      r_w_idx;
    logic [1:0]      r_wb_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_wb_en    <= 1'b0;
            r_alu_res  <= '0;
            r_rs2      <= '0;
            r_pc4      <= '0;
            r_func3    <= '0;
            r_w_idx    <= '0;
            r_wb_sel   <= '0;
        end else if (w_stall || i_flush) begin
            r_valid    <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_wb_en    <= 1'b0;
        end else begin
            r_valid    <= i_valid;
            r_mem_w_en <= i_mem_w_en;
            r_wb_en    <= i_wb_en;
            r_alu_res  <= (r_state == S_DONE) ? w_md_res : w_alu;
            r_rs2      <= w_r2;
            r_pc4      <= i_pc4;
            r_func3    <= i_func3;
            r_w_idx    <= i_w_idx;
            r_wb_sel   <= i_wb_sel;
        end
    end

    assign o_valid    = r_valid;
    assign o_mem_w_en = r_mem_w_en;
    assign o_wb_en    = r_wb_en;
    assign o_alu_res  = r_alu_res;
    assign o_rs2      = r_rs2;
    assign o_pc4      = r_pc4;
    assign o_func3    = r_func3;
    assign o_w_idx    = r_w_idx;
    assign o_wb_sel   = r_wb_sel;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_muldiv
//  Brief    : Directed vectors for execute_muldiv; expected EX/MEM results are
//             queued at issue and popped by an independent output monitor.
//  Revision : 1.0
// ============================================================================
module tb_execute_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid, i_flush;
    logic [XLEN-1:0] i_pc, i_pc4, i_r1, i_r2, i_imm, i_wb_fw_data, i_mem_fw_data;
    logic            i_r1_sel, i_r2_sel;
    logic [1:0]      i_r1_fw_sel, i_r2_fw_sel;
    logic [2:0]      i_func3;
    logic            i_instr30;
    logic [1:0]      i_alu_op, i_branch_op;
    logic            i_is_muldiv, i_mem_w_en, i_wb_en;
    logic [4:0]      i_w_idx;
    logic [1:0]      i_wb_sel;
    logic            o_stall, o_valid, o_mem_w_en, o_wb_en, o_do_branch;
    logic [XLEN-1:0] o_alu_res, o_rs2, o_pc4, o_alu_res_wire;
    logic [2:0]      o_func3;
    logic [4:0]      o_w_idx;
    logic [1:0]      o_wb_sel;

    execute_muldiv #(.XLEN(XLEN), .MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_pc(i_pc), .i_pc4(i_pc4), .i_r1(i_r1), .i_r2(i_r2), .i_imm(i_imm),
        .i_wb_fw_data(i_wb_fw_data), .i_mem_fw_data(i_mem_fw_data),
        .i_r1_sel(i_r1_sel), .i_r2_sel(i_r2_sel),
        .i_r1_fw_sel(i_r1_fw_sel), .i_r2_fw_sel(i_r2_fw_sel),
        .i_func3(i_func3), .i_instr30(i_instr30), .i_alu_op(i_alu_op),
        .i_branch_op(i_branch_op), .i_is_muldiv(i_is_muldiv),
        .i_mem_w_en(i_mem_w_en), .i_wb_en(i_wb_en), .i_w_idx(i_w_idx),
        .i_wb_sel(i_wb_sel),
        .o_stall(o_stall), .o_valid(o_valid), .o_alu_res(o_alu_res),
        .o_rs2(o_rs2), .o_pc4(o_pc4), .o_mem_w_en(o_mem_w_en),
        .o_wb_en(o_wb_en), .o_func3(o_func3), .o_w_idx(o_w_idx),
        .o_wb_sel(o_wb_sel), .o_alu_res_wire(o_alu_res_wire),
        .o_do_branch(o_do_branch)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [4:0]      widx;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_flush = 0; i_pc = 0; i_pc4 = 0; i_r1 = 0; i_r2 = 0; i_imm = 0;
        i_wb_fw_data = 0; i_mem_fw_data = 0; i_r1_sel = 0; i_r2_sel = 0;
        i_r1_fw_sel = 0; i_r2_fw_sel = 0; i_func3 = 0; i_instr30 = 0; i_alu_op = 0;
        i_branch_op = 0; i_is_muldiv = 0; i_mem_w_en = 0; i_wb_en = 0; i_w_idx = 0;
        i_wb_sel = 0;
    endtask

    // Called just after a rising edge; returns just after the edge that retires the op.
    task automatic run_op(input logic md, input logic [2:0] f3, input logic [1:0] aop,
                          input logic i30, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] idx, input int exp_stalls, input logic [31:0] exp_res);
        int  stalls;
        bit  first;
        i_valid = 1; i_is_muldiv = md; i_func3 = f3; i_alu_op = aop; i_instr30 = i30;
        i_r1 = a; i_r2 = b; i_w_idx = idx; i_wb_en = 1; i_pc4 = 32'h100 + {25'd0, idx, 2'b00};
        i_branch_op = md ? 2'b10 : 2'b00;
        sb.push_back('{exp_res, idx, cyc + 1 + exp_stalls});
        stalls = 0;
        first  = 1;
        forever begin
            @(negedge clk);
            if (md && first) check($sformatf("md_no_branch_%0d", idx), o_do_branch, 0);
            first = 0;
            if (!o_stall) break;
            stalls++;
            if (stalls > 64) break;
        end
        check($sformatf("stall_cycles_%0d", idx), stalls, exp_stalls);
        @(posedge clk);
        #1;
        i_valid = 0; i_is_muldiv = 0; i_wb_en = 0; i_branch_op = 0;
    endtask

    task automatic br(input string name, input logic v, input logic fl, input logic md,
                      input logic [1:0] bop, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic exp);
        @(negedge clk);
        i_valid = v; i_flush = fl; i_is_muldiv = md; i_branch_op = bop;
        i_func3 = f3; i_r1 = a; i_r2 = b;
        #1;
        check(name, o_do_branch, exp);
        i_valid = 0; i_flush = 0; i_is_muldiv = 0; i_branch_op = 0;
    endtask

    // Output monitor: every valid EX/MEM entry must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got valid res %h idx %0d, required no valid output",
                         o_alu_res, o_w_idx);
            end else begin
                mon_e = sb.pop_front();
                if (o_alu_res !== mon_e.data || o_w_idx !== mon_e.widx ||
                    o_wb_en !== 1'b1 || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL sb_idx%0d: got res %h idx %0d wb_en %b cyc %0d, required res %h idx %0d wb_en 1 cyc %0d",
                             mon_e.widx, o_alu_res, o_w_idx, o_wb_en, cyc,
                             mon_e.data, mon_e.widx, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1;
        i_valid = 1; i_is_muldiv = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall",  o_stall, 0);
        check("rst_valid",  o_valid, 0);
        check("rst_res",    o_alu_res, 0);
        check("rst_wb_en",  o_wb_en, 0);
        check("rst_w_idx",  o_w_idx, 0);
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();

        br("beq_taken",    1, 0, 0, 2'b01, 3'b000, 32'd5, 32'd5, 1);
        br("bne_not",      1, 0, 0, 2'b01, 3'b001, 32'd5, 32'd5, 0);
        br("blt_taken",    1, 0, 0, 2'b01, 3'b100, 32'hFFFF_FFFF, 32'd1, 1);
        br("bltu_not",     1, 0, 0, 2'b01, 3'b110, 32'hFFFF_FFFF, 32'd1, 0);
        br("bgeu_taken",   1, 0, 0, 2'b01, 3'b111, 32'hFFFF_FFFF, 32'd1, 1);
        br("jump",         1, 0, 0, 2'b10, 3'b000, 32'd0, 32'd0, 1);
        br("jump_invalid", 0, 0, 0, 2'b10, 3'b000, 32'd0, 32'd0, 0);
        br("jump_flushed", 1, 1, 0, 2'b10, 3'b000, 32'd0, 32'd0, 0);
        br("jump_muldiv",  1, 0, 1, 2'b10, 3'b000, 32'd0, 32'd0, 0);
        br("no_branch_op", 1, 0, 0, 2'b00, 3'b000, 32'd5, 32'd5, 0);
        @(posedge clk);
        #1;

        run_op(0, 3'b000, 2'b00, 0, 32'd5, 32'd7, 5'd1, 0, 32'd12);
        i_r1_fw_sel = 2'd1; i_mem_fw_data = 32'd100; i_r2_fw_sel = 2'd2; i_wb_fw_data = 32'd23;
        run_op(0, 3'b000, 2'b00, 0, 32'd1, 32'd1, 5'd2, 0, 32'd123);
        i_r1_fw_sel = 2'd3; i_r2_fw_sel = 2'd3; i_mem_fw_data = 32'd999;
        run_op(0, 3'b000, 2'b00, 0, 32'd40, 32'd2, 5'd3, 0, 32'd42);
        i_r1_fw_sel = 2'd0; i_r2_fw_sel = 2'd0;
        run_op(0, 3'b000, 2'b10, 1, 32'd7, 32'd5, 5'd4, 0, 32'd2);
        run_op(0, 3'b010, 2'b10, 0, 32'hFFFF_FFFF, 32'd1, 5'd5, 0, 32'd1);
        i_r2_sel = 1; i_imm = 32'd4;
        run_op(0, 3'b101, 2'b11, 1, 32'h8000_0000, 32'd0, 5'd6, 0, 32'hF800_0000);
        i_r1_sel = 1; i_pc = 32'h1000; i_imm = 32'h20;
        run_op(0, 3'b000, 2'b00, 0, 32'd0, 32'd0, 5'd7, 0, 32'h1020);
        i_r1_sel = 0; i_r2_sel = 0;

        run_op(1, 3'b000, 2'b00, 0, 32'hFFFF_FFFF, 32'd2, 5'd8,  3, 32'hFFFF_FFFE);
        run_op(1, 3'b011, 2'b00, 0, 32'hFFFF_FFFF, 32'd2, 5'd9,  3, 32'h0000_0001);
        run_op(1, 3'b001, 2'b00, 0, 32'hFFFF_FFFF, 32'd2, 5'd10, 3, 32'hFFFF_FFFF);
        run_op(1, 3'b010, 2'b00, 0, 32'd2, 32'hFFFF_FFFF, 5'd11, 3, 32'h0000_0001);

        run_op(1, 3'b100, 2'b00, 0, 32'hFFFF_FFF9, 32'd2, 5'd12, 33, 32'hFFFF_FFFD);
        run_op(1, 3'b110, 2'b00, 0, 32'hFFFF_FFF9, 32'd2, 5'd13, 33, 32'hFFFF_FFFF);
        run_op(1, 3'b101, 2'b00, 0, 32'd9, 32'd0, 5'd14, 33, 32'hFFFF_FFFF);
        run_op(1, 3'b111, 2'b00, 0, 32'd9, 32'd0, 5'd15, 33, 32'd9);
        run_op(1, 3'b100, 2'b00, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 33, 32'h8000_0000);
        run_op(1, 3'b110, 2'b00, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 33, 32'd0);
        run_op(1, 3'b100, 2'b00, 0, 32'hFFFF_FFFB, 32'd0, 5'd18, 33, 32'hFFFF_FFFF);
        run_op(1, 3'b110, 2'b00, 0, 32'hFFFF_FFFB, 32'd0, 5'd19, 33, 32'hFFFF_FFFB);
        run_op(1, 3'b101, 2'b00, 0, 32'd100, 32'd7, 5'd20, 33, 32'd14);
        run_op(1, 3'b111, 2'b00, 0, 32'd100, 32'd7, 5'd21, 33, 32'd2);
        run_op(1, 3'b100, 2'b00, 0, 32'd7, 32'hFFFF_FFFE, 5'd22, 33, 32'hFFFF_FFFD);
        run_op(1, 3'b110, 2'b00, 0, 32'd7, 32'hFFFF_FFFE, 5'd23, 33, 32'd1);

        // Flush in the 5th BUSY cycle of a divide
        i_valid = 1; i_is_muldiv = 1; i_func3 = 3'b100; i_r1 = 32'd1000; i_r2 = 32'd3;
        i_w_idx = 5'd24; i_wb_en = 1;
        @(negedge clk);
        check("flush_accept_stall", o_stall, 1);
        repeat (5) @(posedge clk);
        #1;
        i_flush = 1;
        #1;
        check("flush_stall", o_stall, 0);
        @(posedge clk);
        #1;
        check("flush_valid", o_valid, 0);
        check("flush_wb_en", o_wb_en, 0);
        i_flush = 0; i_valid = 0; i_is_muldiv = 0; i_wb_en = 0;
        run_op(1, 3'b000, 2'b00, 0, 32'hFFFF_FFFF, 32'd2, 5'd25, 3, 32'hFFFF_FFFE);

        // Reset during BUSY
        i_valid = 1; i_is_muldiv = 1; i_func3 = 3'b100; i_r1 = 32'd50; i_r2 = 32'd5;
        i_w_idx = 5'd26; i_wb_en = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        check("busy_rst_stall",   o_stall, 0);
        check("busy_rst_valid",   o_valid, 0);
        check("busy_rst_res",     o_alu_res, 0);
        check("busy_rst_rs2",     o_rs2, 0);
        check("busy_rst_w_idx",   o_w_idx, 0);
        check("busy_rst_wb_en",   o_wb_en, 0);
        check("busy_rst_mem_w",   o_mem_w_en, 0);
        rst = 0;
        i_valid = 0; i_is_muldiv = 0; i_wb_en = 0;
        run_op(0, 3'b000, 2'b00, 0, 32'd3, 32'd4, 5'd27, 0, 32'd7);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
